enc4to2_capture: RTL and testbench
==================================

Name: enc4to2_capture

Overview:
- Sequential 4-to-2 encoder, the reverse direction of the team's 2-to-4 decoder. It takes four asynchronous one-hot-style request lines D[3:0] and turns them into a 2-bit code A[1:0].
- Each line is synchronized and rising-edge detected. Edges are latched into a pending register.
- Pending requests are issued one at a time as a priority-encoded code on a valid/ready output.
- Used wherever decoder-style line outputs must be converted back to a binary index for downstream logic.

Parameters:
- SYNC_STAGES, 2, depth of the per-line synchronizer flop chain (legal range 2..4).
- LOW_FIRST, 1, priority order. 1: lowest index wins (D0 highest). 0: highest index wins (D3 highest).

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- D, input, 4, asynchronous request lines; a rising edge on D[i] requests code i.
- ready, input, 1, downstream accepts the current code when high together with valid.
- clr_ovf, input, 1, synchronous clear of the ovf flag.
- A, output, 2, encoded index of the granted request.
- valid, output, 1, A holds a granted code.
- pending, output, 4, registered pending-request bitmap.
- multi_hot, output, 1, one-cycle pulse: two or more new edges detected in the same cycle.
- ovf, output, 1, sticky flag: an edge arrived on a line that was already pending.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - All synchronizer flops, the edge-history flops, pending, A, valid, multi_hot and ovf are 0. The FSM goes to IDLE.
  - Reset asserted mid-transfer drops valid at once and discards all pending requests.
- Synchronizer and edge detect:
  - D[i] passes through SYNC_STAGES flops to give s[i]. A history flop holds p[i] <= s[i].
  - rise[i] = s[i] & ~p[i], combinational. A level held high yields exactly one rise.
- Pending register, per bit i each edge:
  - Next value = (pending[i] & ~grant_clr[i]) | rise[i].
  - grant_clr is the one-hot of the index being loaded into A this edge.
  - Set wins over clear. A rise on the bit being granted in the same edge leaves it pending and does not set ovf.
- ovf:
  - Set when rise[i] & pending[i] & ~grant_clr[i] for any i.
  - Cleared by clr_ovf when no set condition occurs in the same cycle; set wins.
- multi_hot: registered. It is 1 for exactly one cycle after any cycle in which popcount(rise) >= 2.
- Priority encode:
  - sel = first set bit of the registered pending, in LOW_FIRST order.
  - Encoding is binary: D0->00, D1->01, D2->10, D3->11.
- FSM, two states (valid = 1 in HOLD):
  - IDLE: if pending != 0, load A <= sel, clear that bit, go to HOLD. Otherwise stay.
  - HOLD, ready = 0: A and valid hold stable. No pending bit is cleared.
  - HOLD, ready = 1 with pending != 0: load the next sel into A, clear that bit, stay in HOLD. This gives back-to-back transfers.
  - HOLD, ready = 1 with pending == 0: valid <= 0, go to IDLE. A retains its last value.
- Latency:
  - For a D[i] rise first sampled at edge k, with the FSM idle and nothing else pending:
  - rise[i] is high after edge k+SYNC_STAGES-1, pending[i] after edge k+SYNC_STAGES, valid after edge k+SYNC_STAGES+1.
  - With SYNC_STAGES=2 this is 3 edges after first sample.
- Throughput: one code per cycle while ready is held high.
- Pulses: a D pulse shorter than one clock period may be missed; this is not guaranteed and not flagged.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-HOLD with pending=4'b0110 -> valid, A, pending, ovf and multi_hot read 0 immediately, before the next clk edge.
- Single request, latency: SYNC_STAGES=2, raise D=4'b0100 and hold with ready=1 -> valid=1 with A=2'b10 exactly 3 edges after first sample. It is valid for one cycle, then IDLE. No second grant while D stays high.
- Simultaneous edges, LOW_FIRST=1: raise D=4'b1010 in one step with ready=1 -> multi_hot pulses once. Grants A=01 then A=11 on consecutive cycles, then valid=0.
- Backpressure and priority, LOW_FIRST=0: same stimulus as the previous scenario with ready=0 for 5 cycles -> A=11 stable with valid=1 throughout. After ready=1, A=01 follows next cycle.
- Overflow: with ready=0 and pending[0]=1 plus one grant in HOLD, toggle D0 low-high again -> ovf=1 and stays set. Pulse clr_ovf -> ovf=0 next edge.
- Set/clear collision: a rise on D1 lands in the exact edge pending[1] is granted -> A=01 issued, pending[1] remains 1, ovf stays 0, a second A=01 grant follows.

Source files
------------

// File: rtl/enc4to2_capture_if.sv
// rtl/enc4to2_capture_if.sv - request/code bundle between the capture encoder and its consumer
interface enc4to2_capture_if;
    logic [3:0] D;
    logic       ready;
    logic       clr_ovf;
    logic [1:0] A;
    logic       valid;
    logic [3:0] pending;
    logic       multi_hot;
    logic       ovf;

    modport master (
        input  D, ready, clr_ovf,
        output A, valid, pending, multi_hot, ovf
    );

    modport slave (
        output D, ready, clr_ovf,
        input  A, valid, pending, multi_hot, ovf
    );
endinterface

// File: rtl/enc4to2_capture.sv
// rtl/enc4to2_capture.sv - edge-captured 4-to-2 priority encoder with valid/ready code output
module enc4to2_capture #(
    parameter int SYNC_STAGES = 2,
    parameter bit LOW_FIRST   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    enc4to2_capture_if.master  bus
);
    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_prev;
    logic [3:0] r_pending;
    logic [1:0] r_a;
    logic       r_multi_hot;
    logic       r_ovf;
    logic [3:0] w_sync;
    logic [3:0] w_rise;
    logic [3:0] w_grant_clr;
    logic [1:0] w_sel;
    logic       w_any;
    logic       w_load;
    logic       w_ovf_set;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_prev;
    assign w_any     = |r_pending;
    assign w_ovf_set = |(w_rise & r_pending & ~w_grant_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= bus.D;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync;
        end
    end

    // Later loop iterations overwrite earlier ones, so the scan order sets priority.
    always_comb begin
        w_sel = 2'd0;
        if (LOW_FIRST) begin
            for (int i = 3; i >= 0; i--) if (r_pending[i]) w_sel = 2'(i);
        end else begin
            for (int i = 0; i < 4; i++) if (r_pending[i]) w_sel = 2'(i);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_load       = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ready) begin
                    if (w_any) w_load = 1'b1;
                    else       w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        w_grant_clr = w_load ? (4'b0001 << w_sel) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_a         <= '0;
            r_multi_hot <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // A fresh rise on the bit being granted keeps it pending.
            r_pending   <= (r_pending & ~w_grant_clr) | w_rise;
            if (w_load) r_a <= w_sel;
            r_multi_hot <= ($countones(w_rise) >= 2);
            if (w_ovf_set)        r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign bus.A         = r_a;
    assign bus.valid     = (r_state == S_HOLD);
    assign bus.pending   = r_pending;
    assign bus.multi_hot = r_multi_hot;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_enc4to2_capture.sv
// tb/tb_enc4to2_capture.sv - random and directed checks of two encoder configurations against a cycle model
module tb_enc4to2_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    enc4to2_capture_if bus0 ();
    enc4to2_capture_if bus1 ();

    enc4to2_capture #(.SYNC_STAGES(2), .LOW_FIRST(1'b1)) u_low  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    enc4to2_capture #(.SYNC_STAGES(3), .LOW_FIRST(1'b0)) u_high (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: per instance, D sample history (index 0 = newest), pending set, output register.
    int         sy [2] = '{2, 3};
    bit         lf [2] = '{1'b1, 1'b0};
    logic [3:0] m_hist [2][5];
    bit         m_pend [2][4];
    bit         m_busy [2];
    int         m_code [2];
    bit         m_ovf  [2];
    bit         m_mh   [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int m);
        if (lf[m]) begin
            for (int i = 0; i < 4; i++) if (m_pend[m][i]) return i;
        end else begin
            for (int i = 3; i >= 0; i--) if (m_pend[m][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 5; k++) m_hist[m][k] = 4'b0;
            for (int i = 0; i < 4; i++) m_pend[m][i] = 1'b0;
            m_busy[m] = 1'b0; m_code[m] = 0; m_ovf[m] = 1'b0; m_mh[m] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] d, input bit rdy, input bit clr);
        for (int m = 0; m < 2; m++) begin
            int  g;
            int  nrise;
            bit  rise [4];
            bit  ovf_set;
            g = pick(m);
            if (g >= 0 && (!m_busy[m] || rdy)) m_code[m] = g;
            else begin
                if (m_busy[m] && rdy) m_busy[m] = 1'b0;
                g = -1;
            end
            if (g >= 0) m_busy[m] = 1'b1;
            nrise = 0; ovf_set = 1'b0;
            for (int i = 0; i < 4; i++) begin
                rise[i] = m_hist[m][sy[m]-1][i] && !m_hist[m][sy[m]][i];
                if (rise[i]) nrise++;
                if (rise[i] && m_pend[m][i] && g != i) ovf_set = 1'b1;
                m_pend[m][i] = (m_pend[m][i] && g != i) || rise[i];
            end
            m_mh[m] = (nrise >= 2);
            if (ovf_set) m_ovf[m] = 1'b1;
            else if (clr) m_ovf[m] = 1'b0;
            for (int k = 4; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
            m_hist[m][0] = d;
        end
    endtask

    function automatic logic [3:0] mpend(input int m);
        return {m_pend[m][3], m_pend[m][2], m_pend[m][1], m_pend[m][0]};
    endfunction

    task automatic cmp_inst(input int m, input logic [1:0] a, input logic v,
                            input logic [3:0] p, input logic mh, input logic ov);
        string s;
        s = (m == 0) ? "low" : "high";
        chk({s, ".valid"}, {7'b0, v}, {7'b0, m_busy[m]});
        chk({s, ".A"}, {6'b0, a}, 8'(m_code[m]));
        chk({s, ".pending"}, {4'b0, p}, {4'b0, mpend(m)});
        chk({s, ".multi_hot"}, {7'b0, mh}, {7'b0, m_mh[m]});
        chk({s, ".ovf"}, {7'b0, ov}, {7'b0, m_ovf[m]});
    endtask

    task automatic compare();
        cmp_inst(0, bus0.A, bus0.valid, bus0.pending, bus0.multi_hot, bus0.ovf);
        cmp_inst(1, bus1.A, bus1.valid, bus1.pending, bus1.multi_hot, bus1.ovf);
    endtask

    // Inputs change at the falling edge; the model advances on each rising edge.
    task automatic cycle(input logic [3:0] d, input bit rdy, input bit clr);
        bus0.D = d; bus0.ready = rdy; bus0.clr_ovf = clr;
        bus1.D = d; bus1.ready = rdy; bus1.clr_ovf = clr;
        @(posedge clk);
        if (rst_n) model_step(d, rdy, clr);
        @(negedge clk);
        compare();
    endtask

    logic [3:0] rd;
    bit         rr;

    initial begin
        bus0.D = 4'b0; bus0.ready = 1'b0; bus0.clr_ovf = 1'b0;
        bus1.D = 4'b0; bus1.ready = 1'b0; bus1.clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // Single request latency on the 2-stage instance.
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        chk("lat.valid_early", {7'b0, bus0.valid}, 8'd0);
        cycle(4'b0100, 1'b1, 1'b0);
        chk("lat.valid", {7'b0, bus0.valid}, 8'd1);
        chk("lat.A", {6'b0, bus0.A}, 8'd2);
        cycle(4'b0100, 1'b1, 1'b0);
        chk("lat.one_shot", {7'b0, bus0.valid}, 8'd0);
        repeat (6) cycle(4'b0000, 1'b1, 1'b0);

        // Simultaneous edges, then backpressure.
        repeat (4) cycle(4'b1010, 1'b0, 1'b0);
        chk("multi.pending_low", {4'b0, bus0.pending}, 8'h08);
        chk("multi.A_low", {6'b0, bus0.A}, 8'd1);
        repeat (5) cycle(4'b1010, 1'b0, 1'b0);
        chk("bp.A_high", {6'b0, bus1.A}, 8'd3);
        chk("bp.valid_high", {7'b0, bus1.valid}, 8'd1);
        repeat (3) cycle(4'b0000, 1'b1, 1'b0);
        repeat (4) cycle(4'b0000, 1'b1, 1'b0);

        // Overflow: D0 retoggled while still pending behind a held grant.
        repeat (4) cycle(4'b0011, 1'b0, 1'b0);
        repeat (2) cycle(4'b0010, 1'b0, 1'b0);
        repeat (4) cycle(4'b0011, 1'b0, 1'b0);
        chk("ovf.set_high", {7'b0, bus1.ovf}, 8'd1);
        cycle(4'b0011, 1'b0, 1'b1);
        chk("ovf.clear_high", {7'b0, bus1.ovf}, 8'd0);
        repeat (6) cycle(4'b0000, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a held grant.
        repeat (5) cycle(4'b0111, 1'b0, 1'b0);
        chk("rst.pre_pending_low", {4'b0, bus0.pending}, 8'h06);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.valid", {7'b0, bus0.valid | bus1.valid}, 8'd0);
        chk("rst.A", {6'b0, bus0.A | bus1.A}, 8'd0);
        chk("rst.pending", {4'b0, bus0.pending | bus1.pending}, 8'd0);
        chk("rst.flags", {6'b0, bus0.ovf | bus1.ovf, bus0.multi_hot | bus1.multi_hot}, 8'd0);
        cycle(4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Random traffic: sparse toggles, random ready, rare ovf clears.
        rd = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) rd[i] = ~rd[i];
            rr = ($urandom_range(0, 3) != 0);
            cycle(rd, rr, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
